// File: rtl/bit_scan_pkg.sv
// bit_scan_pkg: shared state encoding, direction codes and index-width helper for the set-bit scanner.
package bit_scan_pkg;
  typedef enum logic {IDLE, SCAN} state_e;
  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;
  function automatic int idx_w(input int dw);
    return $clog2(dw) + 1;
  endfunction
endpackage

// File: rtl/bit_prio_enc.sv
// bit_prio_enc: combinational lowest/highest set-bit index encoder.
module bit_prio_enc
  import bit_scan_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = idx_w(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] vec,
  input  logic                  msb_first,
  output logic [IDX_W-1:0]      idx,
  output logic                  found
);
  logic [DATA_WIDTH-1:0] rev, src, onehot;
  logic [IDX_W-1:0]      enc;
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_rev
    assign rev[i] = vec[DATA_WIDTH-1-i];
  end
  // MSB-first reuses the lowest-bit isolator on the mirrored word
  assign src    = msb_first ? rev : vec;
  assign onehot = src & (~src + DATA_WIDTH'(1));
  always_comb begin
    enc = '0;
    for (int i = 0; i < DATA_WIDTH; i++) enc = enc | (onehot[i] ? IDX_W'(i) : '0);
  end
  assign found = |vec;
  assign idx   = msb_first ? IDX_W'(DATA_WIDTH - 1) - enc : enc;
endmodule

// File: rtl/set_bit_scanner.sv
// set_bit_scanner: streams the index of every set bit of each accepted word, one beat per cycle.
module set_bit_scanner
  import bit_scan_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = idx_w(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_msb_first,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_idx,
  output logic [IDX_W-1:0]      out_ord,
  output logic                  out_last,
  output logic                  out_empty
);
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [IDX_W-1:0]      ord_q, ord_d, enc_idx;
  logic                  dir_q, dir_d, empty_q, empty_d, up_q;
  logic                  found, scan, beat, acc;

  bit_prio_enc #(.DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_enc (
    .vec      (work_q),
    .msb_first(dir_q == DIR_MSB),
    .idx      (enc_idx),
    .found    (found)
  );

  // up_q keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      work_q  <= '0;
      dir_q   <= DIR_LSB;
      ord_q   <= '0;
      empty_q <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dir_q   <= dir_d;
      ord_q   <= ord_d;
      empty_q <= empty_d;
      up_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d = acc ? SCAN : (beat && out_last) ? IDLE : state_q;
    work_d  = acc ? in_data : beat ? work_q & ~(DATA_WIDTH'(1) << enc_idx) : work_q;
    dir_d   = acc ? in_msb_first : dir_q;
    ord_d   = acc ? '0 : beat ? ord_q + 1'b1 : ord_q;
    empty_d = acc ? (in_data == '0) : empty_q;
  end

  always_comb begin
    scan      = state_q == SCAN;
    out_valid = scan;
    beat      = scan & out_ready;
    out_last  = scan & (empty_q | ((work_q & (work_q - 1'b1)) == '0));
    out_empty = scan & empty_q;
    out_idx   = !scan ? '0 : found ? enc_idx : IDX_W'(DATA_WIDTH);
    out_ord   = scan ? ord_q : '0;
    in_ready  = up_q & (!scan | (beat & out_last));
    acc       = in_valid & in_ready;
  end
endmodule

// File: tb/tb_set_bit_scanner.sv
// tb_set_bit_scanner: random and directed checks of the set-bit scanner against a beat-queue model.
module tb_set_bit_scanner;
  localparam int DW = 32;
  localparam int IW = 6;

  typedef struct {int idx; int ord; bit last; bit empty; bit rdy; int cyc;} beat_t;

  logic clk = 0, resetn = 0;
  logic in_valid = 0, in_msb = 0, out_ready = 1;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid, out_last, out_empty;
  logic [IW-1:0] out_idx, out_ord;
  logic v5 = 0, m5 = 0;
  logic [4:0] d5 = '0;
  logic r5, ov5, ol5, oe5;
  logic [3:0] oi5, oo5;

  beat_t q[$], log_q[$], log5[$];
  int checks = 0, errors = 0, cyc = 0;
  bit up = 0, rnd_rdy = 0, stall_prev = 0, prev_last = 0;
  int prev_idx = 0, prev_ord = 0;

  always #5 clk = ~clk;

  set_bit_scanner #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_msb_first(in_msb), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_ord(out_ord), .out_last(out_last), .out_empty(out_empty)
  );

  set_bit_scanner #(.DATA_WIDTH(5)) dut5 (
    .clk(clk), .resetn(resetn), .in_valid(v5), .in_ready(r5), .in_data(d5),
    .in_msb_first(m5), .out_valid(ov5), .out_ready(1'b1), .out_idx(oi5),
    .out_ord(oo5), .out_last(ol5), .out_empty(oe5)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push_word(input logic [DW-1:0] d, input bit m);
    int n = 0;
    if (d == 0) q.push_back('{DW, 0, 1'b1, 1'b1, 1'b0, 0});
    else begin
      for (int k = 0; k < DW; k++) begin
        int p = m ? DW - 1 - k : k;
        if (d[p]) begin
          q.push_back('{p, n, 1'b0, 1'b0, 1'b0, 0});
          n++;
        end
      end
      q[q.size()-1].last = 1'b1;
    end
  endfunction

  always @(posedge clk) cyc++;
  always @(posedge clk or negedge resetn) up <= resetn;

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    bit ev, er;
    if (!resetn) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_ord", out_ord, 0);
      chk("rst_last", out_last, 0);
      chk("rst_empty", out_empty, 0);
      q.delete();
      stall_prev = 0;
    end else begin
      ev = q.size() > 0;
      er = up && (q.size() == 0 || (q.size() == 1 && out_ready));
      chk("out_valid", out_valid, int'(ev));
      chk("in_ready", in_ready, int'(er));
      if (ev) begin
        chk("idx", out_idx, q[0].idx);
        chk("ord", out_ord, q[0].ord);
        chk("last", out_last, int'(q[0].last));
        chk("empty", out_empty, int'(q[0].empty));
        if (stall_prev) begin
          chk("stall_idx", out_idx, prev_idx);
          chk("stall_ord", out_ord, prev_ord);
          chk("stall_last", out_last, int'(prev_last));
        end
        if (out_ready) begin
          log_q.push_back('{int'(out_idx), int'(out_ord), out_last, out_empty, in_ready, cyc});
          void'(q.pop_front());
        end
      end else begin
        chk("idle_idx", out_idx, 0);
        chk("idle_ord", out_ord, 0);
        chk("idle_last", out_last, 0);
      end
      stall_prev = ev && !out_ready;
      prev_idx = out_idx;
      prev_ord = out_ord;
      prev_last = out_last;
      if (in_valid && er) push_word(in_data, in_msb);
    end
  end

  always @(negedge clk)
    if (resetn && ov5) log5.push_back('{int'(oi5), int'(oo5), ol5, oe5, r5, cyc});

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit m);
    int t = 0;
    in_data = d;
    in_msb = m;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("accept_timeout", int'(t < 500), 1);
    sync();
    in_valid = 0;
  endtask

  task automatic send5(input logic [4:0] d, input bit m);
    int t = 0;
    d5 = d;
    m5 = m;
    v5 = 1;
    @(negedge clk);
    while (!r5 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("accept5_timeout", int'(t < 500), 1);
    sync();
    v5 = 0;
  endtask

  task automatic wait_log(input int n);
    int t = 0;
    while (log_q.size() < n && t < 2000) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk("beat_timeout", int'(log_q.size() >= n), 1);
  endtask

  task automatic wait5(input int n);
    int t = 0;
    while (log5.size() < n && t < 200) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk("beat5_timeout", int'(log5.size() >= n), 1);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 5000) begin
      sync();
      t++;
    end
    chk("drain_timeout", int'(q.size() == 0), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    repeat (3) @(posedge clk);
    #3 resetn = 1;
    @(negedge clk);
    chk("ready_before_edge", in_ready, 0);
    sync();
    chk("ready_after_edge", in_ready, 1);

    log_q.delete();
    send(32'h0000_0028, 0);
    wait_log(2);
    chk("t1_idx0", log_q[0].idx, 3);
    chk("t1_ord0", log_q[0].ord, 0);
    chk("t1_rdy0", log_q[0].rdy, 0);
    chk("t1_idx1", log_q[1].idx, 5);
    chk("t1_ord1", log_q[1].ord, 1);
    chk("t1_last1", log_q[1].last, 1);
    chk("t1_rdy1", log_q[1].rdy, 1);

    sync();
    log_q.delete();
    send(32'h0000_0028, 1);
    send(32'h8000_0001, 1);
    wait_log(4);
    chk("t2_idx0", log_q[0].idx, 5);
    chk("t2_idx1", log_q[1].idx, 3);
    chk("t2_last1", log_q[1].last, 1);
    chk("t2_idx2", log_q[2].idx, 31);
    chk("t2_idx3", log_q[3].idx, 0);

    sync();
    log_q.delete();
    send(32'h0, 0);
    send(32'h1, 0);
    wait_log(2);
    chk("t3_zero_idx", log_q[0].idx, 32);
    chk("t3_zero_empty", log_q[0].empty, 1);
    chk("t3_zero_last", log_q[0].last, 1);
    chk("t3_zero_ord", log_q[0].ord, 0);
    chk("t3_one_idx", log_q[1].idx, 0);
    chk("t3_one_last", log_q[1].last, 1);
    chk("t3_one_empty", log_q[1].empty, 0);

    sync();
    log_q.delete();
    rnd_rdy = 1;
    send(32'hFFFF_FFFF, 0);
    wait_log(32);
    for (int i = 0; i < 32; i++) begin
      chk("t4_idx", log_q[i].idx, i);
      chk("t4_ord", log_q[i].ord, i);
    end
    rnd_rdy = 0;
    sync();
    #1 out_ready = 1;

    sync();
    log_q.delete();
    send(32'h6, 0);
    send(32'h1, 0);
    wait_log(3);
    chk("t5_idx0", log_q[0].idx, 1);
    chk("t5_idx1", log_q[1].idx, 2);
    chk("t5_last1", log_q[1].last, 1);
    chk("t5_idx2", log_q[2].idx, 0);
    chk("t5_last2", log_q[2].last, 1);
    chk("t5_gap01", log_q[1].cyc - log_q[0].cyc, 1);
    chk("t5_gap12", log_q[2].cyc - log_q[1].cyc, 1);

    sync();
    log_q.delete();
    send(32'hF0, 0);
    wait_log(2);
    resetn = 0;
    #1;
    chk("t6_valid_async", out_valid, 0);
    chk("t6_ready_async", in_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #3 resetn = 1;
    @(negedge clk);
    chk("t6_ready_before_edge", in_ready, 0);
    sync();
    chk("t6_ready", in_ready, 1);
    chk("t6_valid", out_valid, 0);
    repeat (3) sync();
    chk("t6_no_residual", log_q.size(), 2);

    rnd_rdy = 1;
    for (int w = 0; w < 300; w++) begin
      case ($urandom_range(0, 3))
        0: d = '0;
        1: d = DW'(1) << $urandom_range(0, DW - 1);
        2: d = $urandom;
        default: d = $urandom & $urandom & $urandom;
      endcase
      send(d, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) sync();
    end
    drain();
    rnd_rdy = 0;
    sync();
    #1 out_ready = 1;

    log5.delete();
    send5(5'b01010, 0);
    send5(5'b01010, 1);
    send5(5'b10001, 1);
    send5(5'b00000, 0);
    send5(5'b00001, 0);
    wait5(8);
    chk("d5_a0", log5[0].idx, 1);
    chk("d5_a1", log5[1].idx, 3);
    chk("d5_a1_last", log5[1].last, 1);
    chk("d5_b0", log5[2].idx, 3);
    chk("d5_b1", log5[3].idx, 1);
    chk("d5_c0", log5[4].idx, 4);
    chk("d5_c1", log5[5].idx, 0);
    chk("d5_c1_ord", log5[5].ord, 1);
    chk("d5_zero_idx", log5[6].idx, 5);
    chk("d5_zero_empty", log5[6].empty, 1);
    chk("d5_zero_last", log5[6].last, 1);
    chk("d5_zero_ord", log5[6].ord, 0);
    chk("d5_one_idx", log5[7].idx, 0);
    chk("d5_one_last", log5[7].last, 1);
    chk("d5_one_empty", log5[7].empty, 0);

    repeat (3) sync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
